// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and the
// ASCII codes the downstream colour command parser matches against.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_B     = 8'h62;
    localparam logic [7:0] ASCII_G     = 8'h67;
    localparam logic [7:0] ASCII_R     = 8'h72;

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for asynchronous single-bit inputs (serial lines, buttons).
// Both flops take RESET_VALUE so the output holds the line's idle level in reset.
module bit_synchronizer #(
    parameter bit RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised rx line, one-cycle
// valid strobe per good byte and one-cycle framing_error pulse on a bad stop bit.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_data_valid,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(HALF_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    logic          rx_s;
    rx_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    data_next;
    logic          valid_next, ferr_next;

    bit_synchronizer #(.RESET_VALUE(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_WAIT_IDLE;
            cnt             <= '0;
            idx             <= '0;
            shift           <= '0;
            uart_data       <= '0;
            uart_data_valid <= 1'b0;
            framing_error   <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            idx             <= idx_next;
            shift           <= shift_next;
            uart_data       <= data_next;
            uart_data_valid <= valid_next;
            framing_error   <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        data_next  = uart_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        unique case (state)
            // A full bit time of continuous idle is required before a start
            // bit is trusted, so a reset mid-frame or a break cannot misframe.
            ST_WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_next = '0;
                end else if (cnt == LAST_BIT) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt == LAST_HALF) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        idx_next   = '0;
                        state_next = ST_DATA;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == LAST_BIT) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    idx_next   = idx + 1'b1;
                    if (idx == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            // Returning to IDLE at the stop-bit midpoint leaves half a bit of
            // margin to catch a back-to-back start bit.
            ST_STOP: begin
                if (cnt == LAST_BIT) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_WAIT_IDLE;
            end
        endcase
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at 10 clocks per bit: directed frames, a pulse
// expectation queue with a latency window, and a per-cycle held-data model.
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int LAT      = 2 + HALF + 9 * CPB;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] uart_data;
    logic       uart_data_valid;
    logic       framing_error;
    logic       rx_busy;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .uart_data       (uart_data),
        .uart_data_valid (uart_data_valid),
        .framing_error   (framing_error),
        .rx_busy         (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         due_q[$];
    int         vcyc_q[$];
    logic [7:0] hold_data = 8'h00;
    logic       chk_en = 1'b0;
    logic [8:0] e_cur;
    int         d_cur;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expectation entry: bit 8 set means a framing error, else bits 7:0 are the byte.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic expect_it);
        if (expect_it) begin
            exp_q.push_back({~stop, data});
            due_q.push_back(cyc + LAT);
        end
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_err_exclusive", {31'b0, uart_data_valid & framing_error}, 32'd0);
            if (uart_data_valid || framing_error) begin
                if (uart_data_valid) vcyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual valid=%b err=%b data=%h required no pulse (cycle %0d)",
                             uart_data_valid, framing_error, uart_data, cyc);
                end else begin
                    e_cur = exp_q.pop_front();
                    d_cur = due_q.pop_front();
                    check("pulse_kind_err", {31'b0, framing_error}, {31'b0, e_cur[8]});
                    if (!e_cur[8]) begin
                        check("rx_byte", {24'b0, uart_data}, {24'b0, e_cur[7:0]});
                        hold_data = e_cur[7:0];
                    end
                    check("pulse_cycle", cyc, (cyc >= d_cur - 1 && cyc <= d_cur + 1) ? cyc : d_cur);
                end
            end else if (due_q.size() != 0 && cyc > due_q[0] + 1) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse actual none by cycle %0d required kind=%b data=%h near cycle %0d",
                         cyc, exp_q[0][8], exp_q[0][7:0], due_q[0]);
                e_cur = exp_q.pop_front();
                d_cur = due_q.pop_front();
            end
            check("uart_data_hold", {24'b0, uart_data}, {24'b0, hold_data});
        end
    end

    logic [7:0] frame62 = 8'h62;
    int         nv;
    int         k;
    int         start_cyc;
    int         lat;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_uart_data", {24'b0, uart_data}, 32'h00);
        check("reset_valid", {31'b0, uart_data_valid}, 32'd0);
        check("reset_ferr", {31'b0, framing_error}, 32'd0);
        check("reset_busy", {31'b0, rx_busy}, 32'd1);
        reset = 1'b0;
        repeat (20) tick();
        check("idle_busy", {31'b0, rx_busy}, 32'd0);

        send_frame(8'h72, 1'b1, 1'b1);
        repeat (5) tick();
        check("byte_72_literal", {24'b0, uart_data}, 32'h72);
        check("busy_after_72", {31'b0, rx_busy}, 32'd0);

        nv = vcyc_q.size();
        send_frame(8'h52, 1'b1, 1'b1);
        send_frame(8'h46, 1'b1, 1'b1);
        send_frame(8'h77, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (5) tick();
        check("b2b_count", vcyc_q.size(), nv + 3);
        if (vcyc_q.size() >= nv + 3) begin
            check("b2b_spacing_1", vcyc_q[nv+1] - vcyc_q[nv], 32'd100);
            check("b2b_spacing_2", vcyc_q[nv+2] - vcyc_q[nv+1], 32'd100);
        end
        check("byte_77_literal", {24'b0, uart_data}, 32'h77);

        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        k = 0;
        while (rx_busy && k < 7) begin
            tick();
            k++;
        end
        check("glitch_busy_clear", {31'b0, rx_busy}, 32'd0);
        repeat (20) tick();
        send_frame(8'h30, 1'b1, 1'b1);
        repeat (5) tick();
        check("byte_30_literal", {24'b0, uart_data}, 32'h30);

        send_frame(8'h41, 1'b0, 1'b1);
        repeat (30) tick();
        check("break_busy", {31'b0, rx_busy}, 32'd1);
        check("ferr_keeps_data", {24'b0, uart_data}, 32'h30);
        rx = 1'b1;
        repeat (15) tick();
        send_frame(8'h33, 1'b1, 1'b1);
        repeat (5) tick();
        check("byte_33_literal", {24'b0, uart_data}, 32'h33);

        // Reset is held into bit 6 so the remaining high run stays shorter than
        // one bit time and the tail of the aborted frame cannot look like a start.
        nv = vcyc_q.size();
        for (int t = 0; t < 100; t++) begin
            if (t < 10)      rx = 1'b0;
            else if (t < 90) rx = frame62[(t - 10) / 10];
            else             rx = 1'b1;
            if (t == 55) reset = 1'b1;
            if (t == 75) reset = 1'b0;
            tick();
            if (t == 55) hold_data = 8'h00;
            if (t == 60) begin
                check("midreset_data", {24'b0, uart_data}, 32'h00);
                check("midreset_busy", {31'b0, rx_busy}, 32'd1);
            end
        end
        rx = 1'b1;
        repeat (20) tick();
        send_frame(8'h62, 1'b1, 1'b1);
        repeat (5) tick();
        check("byte_62_literal", {24'b0, uart_data}, 32'h62);
        check("midreset_pulses", vcyc_q.size(), nv + 1);

        repeat (10) tick();
        nv = vcyc_q.size();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (5) tick();
        check("a5_single_pulse", vcyc_q.size(), nv + 1);
        if (vcyc_q.size() > nv) begin
            lat = vcyc_q[nv] - start_cyc;
            checks++;
            if (lat < 96 || lat > 98) begin
                errors++;
                $display("FAIL latency_a5 actual=%0d required=97+-1", lat);
            end
        end
        check("byte_a5_literal", {24'b0, uart_data}, 32'hA5);

        repeat (10) tick();
        check("exp_queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
